// File: rtl/soc.sv
// soc: 16-bit accumulator/index CPU with a 512x16 word memory.
module soc_mem (
  input  logic        clk,
  input  logic [8:0]  addr_i,
  input  logic        we_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);
  logic [15:0] mem [0:511];
`ifdef SOC_MEM_INIT_EN
  initial begin
    logic [15:0] p [0:13];
    p = '{16'h0408, 16'h0A09, 16'h140A, 16'h0C0B, 16'h120C, 16'h180D, 16'h040D,
          16'h0000, 16'h1234, 16'h1235, 16'h1236, 16'h1237, 16'h1238, 16'h1239};
    for (int i = 0; i < 512; i++) mem[i] = (i < 14) ? p[i] : '0;
  end
`else
  initial for (int i = 0; i < 512; i++) mem[i] = '0;
`endif
  always_ff @(posedge clk) if (we_i) mem[addr_i] <= wdata_i;
  assign rdata_o = mem[addr_i];
endmodule

module soc_cpu (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start_i,
  input  logic [15:0] rdata_i,
  output logic [15:0] addr_o,
  output logic        we_o,
  output logic [15:0] wdata_o,
  output logic        finish_o
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, HALT} state_e;
  state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, ir_q, ir_d, ac_q, ac_d, ar_q, ar_d, x_q, x_d, y_q, y_d, sp_q;
  logic [3:0] flags_q;
  logic finish_q, finish_d, unused;
  logic [5:0] op;
  logic sel;
  logic [15:0] idx;
  assign op = ir_q[15:10];
  assign sel = ir_q[9];
  assign idx = sel ? y_q : x_q;
  assign unused = ^{sp_q, flags_q};
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    ac_d = ac_q;
    ar_d = ar_q;
    x_d = x_q;
    y_d = y_q;
    finish_d = state_q == HALT;
    case (state_q)
      IDLE: state_d = start_i ? FETCH : IDLE;
      FETCH: begin
        ir_d = rdata_i;
        pc_d = pc_q + 16'd1;
        state_d = DECODE;
      end
      DECODE: begin
        ar_d = {7'd0, (op == 6'd2 || op == 6'd4) ? idx[8:0] + ir_q[8:0] : ir_q[8:0]};
        state_d = (op == 6'd0) ? HALT : EXEC;
      end
      EXEC: begin
        x_d = (op == 6'd1 && !sel) ? rdata_i : x_q;
        y_d = (op == 6'd1 && sel) ? rdata_i : y_q;
        ac_d = (op == 6'd2 || op == 6'd5) ? rdata_i : ac_q;
        state_d = FETCH;
      end
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      pc_q <= '0;
      ir_q <= '0;
      ac_q <= '0;
      ar_q <= '0;
      x_q <= '0;
      y_q <= '0;
      sp_q <= '0;
      flags_q <= '0;
      finish_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      ac_q <= ac_d;
      ar_q <= ar_d;
      x_q <= x_d;
      y_q <= y_d;
      finish_q <= finish_d;
    end
  end
  assign addr_o = (state_q == FETCH) ? pc_q : ar_q;
  assign we_o = state_q == EXEC && (op == 6'd3 || op == 6'd4 || op == 6'd6);
  assign wdata_o = (op == 6'd3) ? idx : ac_q;
  assign finish_o = finish_q;
endmodule

module soc (
  input  logic clk,
  input  logic rst_b,
  input  logic start,
  output logic finish
);
  logic [15:0] addr, wdata, rdata;
  logic we, unused_addr;
  soc_cpu cpu (
    .clk(clk), .rst_b(rst_b), .start_i(start), .rdata_i(rdata),
    .addr_o(addr), .we_o(we), .wdata_o(wdata), .finish_o(finish)
  );
  soc_mem memory (
    .clk(clk), .addr_i(addr[8:0]), .we_i(we), .wdata_i(wdata), .rdata_o(rdata)
  );
  assign unused_addr = ^addr[15:9];
endmodule

// File: tb/tb_soc.sv
// tb_soc: directed checks of reset, program execution, timing, halt and index wrap.
module tb_soc;
  logic clk = 1'b0, rst_b, start, finish;
  int checks = 0, fails = 0, lat;
  soc dut (.clk(clk), .rst_b(rst_b), .start(start), .finish(finish));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 512; i++) dut.memory.mem[i] = 16'h0000;
  endtask
  task automatic load_main();
    logic [15:0] p [0:13];
    p = '{16'h0408, 16'h0A09, 16'h140A, 16'h0C0B, 16'h120C, 16'h180D, 16'h040D,
          16'h0000, 16'h1234, 16'h1235, 16'h1236, 16'h1237, 16'h1238, 16'h1239};
    clear_mem();
    for (int i = 0; i < 14; i++) dut.memory.mem[i] = p[i];
    dut.memory.mem[11] = 16'hBEEF;
  endtask
  task automatic run(output int n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!finish && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask
  task automatic check_main(input string s);
    check({s, "_finish"}, {15'd0, finish}, 16'h0001);
    check({s, "_x"}, dut.cpu.x_q, 16'h1236);
    check({s, "_ac"}, dut.cpu.ac_q, 16'h1236);
    check({s, "_y"}, dut.cpu.y_q, 16'h0000);
    check({s, "_m00b"}, dut.memory.mem[11], 16'h1234);
    check({s, "_m00c"}, dut.memory.mem[12], 16'h1236);
    check({s, "_m00d"}, dut.memory.mem[13], 16'h1236);
    check({s, "_m008"}, dut.memory.mem[8], 16'h1234);
    check({s, "_m009"}, dut.memory.mem[9], 16'h1235);
    check({s, "_m00a"}, dut.memory.mem[10], 16'h1236);
  endtask
  initial begin
    rst_b = 1'b0;
    start = 1'b0;
    load_main();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    check("rst_pc", dut.cpu.pc_q, 16'h0000);
    check("rst_ir", dut.cpu.ir_q, 16'h0000);
    check("rst_ac", dut.cpu.ac_q, 16'h0000);
    check("rst_x", dut.cpu.x_q, 16'h0000);
    check("rst_y", dut.cpu.y_q, 16'h0000);
    check("rst_finish", {15'd0, finish}, 16'h0000);
    repeat (20) @(negedge clk);
    check("idle_pc", dut.cpu.pc_q, 16'h0000);
    check("idle_finish", {15'd0, finish}, 16'h0000);
    run(lat);
    check("run_latency", lat[15:0], 16'd24);
    check_main("run");
    start = 1'b1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    check("halt_finish", {15'd0, finish}, 16'h0001);
    check("halt_pc", dut.cpu.pc_q, 16'h0008);
    rst_b = 1'b0;
    load_main();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    check("mid_pc", dut.cpu.pc_q, 16'h0000);
    check("mid_ac", dut.cpu.ac_q, 16'h0000);
    check("mid_x", dut.cpu.x_q, 16'h0000);
    check("mid_ir", dut.cpu.ir_q, 16'h0000);
    check("mid_finish", {15'd0, finish}, 16'h0000);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    check("mid_m00b", dut.memory.mem[11], 16'hBEEF);
    run(lat);
    check("rerun_latency", lat[15:0], 16'd24);
    check_main("rerun");
    rst_b = 1'b0;
    clear_mem();
    dut.memory.mem[0] = 16'h0610;
    dut.memory.mem[1] = 16'h0A02;
    dut.memory.mem[2] = 16'hFC05;
    dut.memory.mem[3] = 16'h0000;
    dut.memory.mem[5] = 16'h7777;
    dut.memory.mem[16] = 16'h01FF;
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    run(lat);
    check("wrap_latency", lat[15:0], 16'd12);
    check("wrap_y", dut.cpu.y_q, 16'h01FF);
    check("wrap_ac", dut.cpu.ac_q, 16'h0A02);
    check("nop_x", dut.cpu.x_q, 16'h0000);
    check("nop_m005", dut.memory.mem[5], 16'h7777);
    check("wrap_pc", dut.cpu.pc_q, 16'h0004);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
